// File: rtl/regfile_writeback_if.sv
// Bundle of the writeback controller's issue, ALU, load, decode-query and register-file signals.
interface regfile_writeback_if #(
   parameter int unsigned DATA_W = 64
);
   logic              issue_valid;
   logic [4:0]        issue_rd;
   logic              alu_valid;
   logic [4:0]        alu_rd;
   logic [DATA_W-1:0] alu_data;
   logic              mem_valid;
   logic [4:0]        mem_rd;
   logic [DATA_W-1:0] mem_data;
   logic              mem_ready;
   logic [4:0]        RS1;
   logic [4:0]        RS2;
   logic              hazard_rs1;
   logic              hazard_rs2;
   logic [31:0]       busy_mask;
   logic [4:0]        RD;
   logic [DATA_W-1:0] WriteData;
   logic              RegWrite;
   logic              sb_conflict;

   // Pipeline side: drives issue/results/queries, observes write port and scoreboard.
   modport master (
      output issue_valid, issue_rd, alu_valid, alu_rd, alu_data,
      output mem_valid, mem_rd, mem_data, RS1, RS2,
      input  mem_ready, hazard_rs1, hazard_rs2, busy_mask,
      input  RD, WriteData, RegWrite, sb_conflict
   );

   // Controller side.
   modport slave (
      input  issue_valid, issue_rd, alu_valid, alu_rd, alu_data,
      input  mem_valid, mem_rd, mem_data, RS1, RS2,
      output mem_ready, hazard_rs1, hazard_rs2, busy_mask,
      output RD, WriteData, RegWrite, sb_conflict
   );
endinterface

// File: rtl/regfile_writeback_ctrl.sv
// Register-file write-side controller: merges single-cycle ALU results and queued load results
// into one registered write port, and keeps a pending-destination scoreboard for RAW stalls.
module regfile_writeback_ctrl #(
   parameter int unsigned DATA_W   = 64,
   parameter int unsigned LQ_DEPTH = 4
) (
   input logic                clk,
   input logic                reset,
   regfile_writeback_if.slave bus
);
   localparam int unsigned PTR_W = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] LQ_FULL = CNT_W'(LQ_DEPTH);

   logic [4:0]        lq_rd_q   [LQ_DEPTH];
   logic [DATA_W-1:0] lq_data_q [LQ_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [31:0]       busy_q, busy_d;
   logic [4:0]        rd_q, rd_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              regwrite_q, regwrite_d;
   logic              conflict_q, conflict_d;

   logic              mem_ready;
   logic              push, pop, sel_valid, wr_en, issue_set, clear_hit;
   logic [4:0]        sel_rd;
   logic [DATA_W-1:0] sel_data;

   // Write-source selection: ALU always wins, otherwise drain the load queue head.
   always_comb begin
      mem_ready = (count_q != LQ_FULL) && !reset;
      push      = bus.mem_valid && mem_ready;
      pop       = !bus.alu_valid && (count_q != '0);
      sel_valid = bus.alu_valid || pop;
      sel_rd    = bus.alu_valid ? bus.alu_rd : lq_rd_q[rd_ptr_q];
      sel_data  = bus.alu_valid ? bus.alu_data : lq_data_q[rd_ptr_q];
      // x0 entries are consumed but never written
      wr_en     = sel_valid && (sel_rd != 5'd0);
      issue_set = bus.issue_valid && (bus.issue_rd != 5'd0);
      clear_hit = wr_en && (sel_rd == bus.issue_rd);
   end

   // Next-state for queue pointers, write port and scoreboard.
   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
         count_d = count_q - CNT_W'(1);
      end
      rd_d       = sel_valid ? sel_rd : rd_q;
      wdata_d    = sel_valid ? sel_data : wdata_q;
      regwrite_d = wr_en;
      // Clear first so a same-cycle re-issue to the written register leaves it busy
      busy_d = busy_q;
      if (wr_en) begin
         busy_d[sel_rd] = 1'b0;
      end
      if (issue_set) begin
         busy_d[bus.issue_rd] = 1'b1;
      end
      busy_d[0]  = 1'b0;
      conflict_d = conflict_q || (issue_set && busy_q[bus.issue_rd] && !clear_hit);
   end

   // Control and write-port state with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         busy_q     <= '0;
         rd_q       <= '0;
         wdata_q    <= '0;
         regwrite_q <= 1'b0;
         conflict_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         busy_q     <= busy_d;
         rd_q       <= rd_d;
         wdata_q    <= wdata_d;
         regwrite_q <= regwrite_d;
         conflict_q <= conflict_d;
      end
   end

   // Queue storage; validity is tracked by the pointers so no reset is needed.
   always_ff @(posedge clk) begin
      if (push) begin
         lq_rd_q[wr_ptr_q]   <= bus.mem_rd;
         lq_data_q[wr_ptr_q] <= bus.mem_data;
      end
   end

   assign bus.mem_ready   = mem_ready;
   assign bus.hazard_rs1  = (bus.RS1 != 5'd0) && busy_q[bus.RS1];
   assign bus.hazard_rs2  = (bus.RS2 != 5'd0) && busy_q[bus.RS2];
   assign bus.busy_mask   = busy_q;
   assign bus.RD          = rd_q;
   assign bus.WriteData   = wdata_q;
   assign bus.RegWrite    = regwrite_q;
   assign bus.sb_conflict = conflict_q;
endmodule
